ap_pass_ctrl: RTL and testbench

AP_PASS_CTRL -- requirements
Module: ap_pass_ctrl

---
 rtl/ap_pass_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ap_pass_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_pass_ctrl.sv
// ap_pass_ctrl: multi-pass compare/write sequencer for an associative (CAM) array.
// It holds a small table of {key, mask, data} passes. On start it runs each pass in two
// cycles: CMP presents key/mask and captures the match tags, then WR writes data to every
// tagged row in parallel. While idle, a host port gets direct single-row read/write access.
//
// Ports:
//   CLK100MHZ, rst           clock, asynchronous active-low reset
//   host_req/we/addr/wdata   host single-row access request (IDLE only)
//   host_gnt, host_rdata     grant, and read data (live while granted, held otherwise)
//   pass_wr/idx/key/mask/data  pass-table programming (IDLE only)
//   num_passes, start        number of passes to run (clamped to MAX_PASSES), launch
//   busy, done, any_match    status; done is a one-cycle pulse
//   cam_*                    CAM-side address, mode, data, key/mask, write enables, tags
module ap_pass_ctrl #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned CELL_QUANT = 512,
    parameter int unsigned MAX_PASSES = 8,
    localparam int unsigned AW = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1,
    localparam int unsigned PW = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [AW-1:0]         host_addr,
    input  logic [WORD_SIZE-1:0]  host_wdata,
    output logic                  host_gnt,
    output logic [WORD_SIZE-1:0]  host_rdata,
    input  logic                  pass_wr,
    input  logic [PW-1:0]         pass_idx,
    input  logic [WORD_SIZE-1:0]  pass_key,
    input  logic [WORD_SIZE-1:0]  pass_mask,
    input  logic [WORD_SIZE-1:0]  pass_data,
    input  logic [PW:0]           num_passes,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  any_match,
    output logic [AW-1:0]         cam_addr,
    output logic                  cam_mode,
    output logic [WORD_SIZE-1:0]  cam_dina,
    output logic [WORD_SIZE-1:0]  cam_key,
    output logic [WORD_SIZE-1:0]  cam_mask,
    output logic                  cam_wea,
    output logic [CELL_QUANT-1:0] cam_wea_ctrl_ap,
    input  logic [CELL_QUANT-1:0] cam_tags,
    input  logic [WORD_SIZE-1:0]  cam_doutb
);

    typedef logic [PW:0] cnt_t;
    typedef enum logic [1:0] {StIdle, StCmp, StWr, StDone} state_t;

    state_t                  state_q, state_d;
    cnt_t                    n_q;
    cnt_t                    p_q;
    cnt_t                    p_inc;
    cnt_t                    n_start;
    logic [CELL_QUANT-1:0]   tag_q;
    logic                    any_q;
    logic [WORD_SIZE-1:0]    rdata_q;
    logic [WORD_SIZE-1:0]    key_q  [MAX_PASSES];
    logic [WORD_SIZE-1:0]    mask_q [MAX_PASSES];
    logic [WORD_SIZE-1:0]    data_q [MAX_PASSES];
    logic [PW-1:0]           p_idx;
    logic                    launch;

    assign p_idx   = p_q[PW-1:0];
    assign p_inc   = p_q + cnt_t'(1);
    assign n_start = (num_passes > cnt_t'(MAX_PASSES)) ? cnt_t'(MAX_PASSES) : num_passes;
    assign launch  = (state_q == StIdle) && start;

    // State register
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (n_start == '0) ? StDone : StCmp;
            StCmp:   state_d = StWr;
            StWr:    state_d = (p_inc < n_q) ? StCmp : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pass counter, tag capture, match flag and held host read data
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            n_q     <= '0;
            p_q     <= '0;
            tag_q   <= '0;
            any_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (launch) begin
                n_q   <= n_start;
                p_q   <= '0;
                any_q <= 1'b0;
            end
            if (state_q == StCmp) begin
                tag_q <= cam_tags;
                if (|cam_tags) any_q <= 1'b1;
            end
            if (state_q == StWr) p_q <= p_inc;
            if (host_gnt && !host_we) rdata_q <= cam_doutb;
        end
    end

    // Pass table, writable only while idle
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(MAX_PASSES); i++) begin
                key_q[i]  <= '0;
                mask_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (pass_wr && (state_q == StIdle)) begin
            key_q[pass_idx]  <= pass_key;
            mask_q[pass_idx] <= pass_mask;
            data_q[pass_idx] <= pass_data;
        end
    end

    // Outputs; start takes priority over a same-cycle host request
    always_comb begin
        host_gnt        = host_req && (state_q == StIdle) && !start;
        host_rdata      = host_gnt ? cam_doutb : rdata_q;
        busy            = (state_q != StIdle);
        done            = (state_q == StDone);
        any_match       = any_q;
        cam_addr        = '0;
        cam_mode        = 1'b0;
        cam_dina        = '0;
        cam_key         = '0;
        cam_mask        = '0;
        cam_wea         = 1'b0;
        cam_wea_ctrl_ap = '0;
        if (host_gnt) begin
            cam_addr = host_addr;
            cam_dina = host_wdata;
            cam_wea  = host_we;
        end
        if (state_q == StCmp) begin
            cam_key  = key_q[p_idx];
            cam_mask = mask_q[p_idx];
        end
        if (state_q == StWr) begin
            // A pass with no matches still spends this cycle with an all-zero enable vector
            cam_mode        = 1'b1;
            cam_wea_ctrl_ap = tag_q;
            cam_dina        = data_q[p_idx];
        end
    end

endmodule

// File: tb/tb_ap_pass_ctrl.sv
module tb_ap_pass_ctrl;
    localparam int WS = 8;
    localparam int CQ = 512;
    localparam int MP = 8;
    localparam int AW = 9;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req, host_we, host_gnt;
    logic [AW-1:0] host_addr;
    logic [WS-1:0] host_wdata, host_rdata;
    logic          pass_wr;
    logic [PW-1:0] pass_idx;
    logic [WS-1:0] pass_key, pass_mask, pass_data;
    logic [PW:0]   num_passes;
    logic          start, busy, done, any_match;
    logic [AW-1:0] cam_addr;
    logic          cam_mode, cam_wea;
    logic [WS-1:0] cam_dina, cam_key, cam_mask, cam_doutb;
    logic [CQ-1:0] cam_wea_ctrl_ap, cam_tags;

    always #5 clk = ~clk;

    ap_pass_ctrl dut (
        .CLK100MHZ(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .pass_wr(pass_wr), .pass_idx(pass_idx), .pass_key(pass_key),
        .pass_mask(pass_mask), .pass_data(pass_data), .num_passes(num_passes),
        .start(start), .busy(busy), .done(done), .any_match(any_match),
        .cam_addr(cam_addr), .cam_mode(cam_mode), .cam_dina(cam_dina),
        .cam_key(cam_key), .cam_mask(cam_mask), .cam_wea(cam_wea),
        .cam_wea_ctrl_ap(cam_wea_ctrl_ap), .cam_tags(cam_tags), .cam_doutb(cam_doutb)
    );

    // Behavioural CAM: single-row writes in mode 0, parallel tagged writes in mode 1
    logic [WS-1:0] mem      [CQ];
    logic [WS-1:0] init_mem [CQ];
    logic          load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < CQ; i++) mem[i] <= init_mem[i];
        end else begin
            if (cam_wea && !cam_mode) mem[cam_addr] <= cam_dina;
            if (cam_mode) begin
                for (int i = 0; i < CQ; i++) if (cam_wea_ctrl_ap[i]) mem[i] <= cam_dina;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CQ; i++) cam_tags[i] = (((mem[i] ^ cam_key) & cam_mask) == '0);
    end
    assign cam_doutb = mem[cam_addr];

    // Reference state
    logic [WS-1:0] exp_mem  [CQ];
    logic [WS-1:0] tbl_key  [MP];
    logic [WS-1:0] tbl_mask [MP];
    logic [WS-1:0] tbl_data [MP];

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [WS-1:0] wdata;
        bit            exp_gnt;
        bit            chk_rd;
        logic [WS-1:0] exp_rd;
    } host_vec_t;

    typedef struct {
        logic [PW:0] np;
        int          exp_lat;
        bit          exp_any;
        bit          exp_ap;
    } lat_vec_t;

    host_vec_t hv [7];
    lat_vec_t  lv [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int r = 0; r < CQ; r++) exp_mem[r] = init_mem[r];
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic prog(input int idx, input logic [WS-1:0] k, input logic [WS-1:0] m,
                        input logic [WS-1:0] d);
        pass_wr = 1'b1; pass_idx = PW'(idx); pass_key = k; pass_mask = m; pass_data = d;
        step();
        pass_wr = 1'b0;
        tbl_key[idx] = k; tbl_mask[idx] = m; tbl_data[idx] = d;
    endtask

    // Apply passes in order to the expected memory: each pass rewrites every matching row
    task automatic model_run(input int np, output bit any);
        int n;
        n   = (np > MP) ? MP : np;
        any = 1'b0;
        for (int p = 0; p < n; p++) begin
            int hits[$];
            for (int r = 0; r < CQ; r++)
                if (((exp_mem[r] ^ tbl_key[p]) & tbl_mask[p]) == '0) hits.push_back(r);
            if (hits.size() > 0) any = 1'b1;
            foreach (hits[k]) exp_mem[hits[k]] = tbl_data[p];
        end
    endtask

    function automatic int mem_diff();
        int c = 0;
        for (int r = 0; r < CQ; r++) if (mem[r] !== exp_mem[r]) c++;
        return c;
    endfunction

    // Launch a run and count cycles from the start edge to the done cycle. With spam set,
    // host and pass-table requests are held active for the whole busy period.
    task automatic run(input logic [PW:0] np, input bit spam, output int lat,
                       output bit saw_ap, output int busy_gnt);
        saw_ap = 1'b0; busy_gnt = 0;
        num_passes = np; start = 1'b1; host_req = spam; host_we = 1'b0;
        #1;
        if (spam) chk("gnt_vs_start", host_gnt, 0);
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        lat = 1;
        while (!done && lat < 100) begin
            if (spam) begin
                pass_wr = 1'b1; pass_idx = '0; pass_key = 8'hAB; pass_mask = 8'hFF;
                pass_data = 8'h55; host_req = 1'b1; host_we = 1'b1; host_addr = 9'd1;
                host_wdata = 8'hEE;
                #1;
                if (host_gnt) busy_gnt++;
            end
            if (cam_wea_ctrl_ap != '0) saw_ap = 1'b1;
            step();
            lat++;
        end
        if (host_gnt) busy_gnt++;
        if (cam_wea_ctrl_ap != '0) saw_ap = 1'b1;
        pass_wr = 1'b0; host_req = 1'b0; host_we = 1'b0;
        step();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int      lat, bg, dn;
        bit      ap, eany;
        logic [WS-1:0] masks [6];
        logic [PW:0]   np;
        logic [AW-1:0] a;

        masks = '{8'hFF, 8'h07, 8'h03, 8'h01, 8'h06, 8'h00};
        hv[0] = '{1, 1, 9'd3,   8'h5A, 1, 0, 8'h00};
        hv[1] = '{1, 0, 9'd3,   8'h00, 1, 1, 8'h5A};
        hv[2] = '{0, 0, 9'd0,   8'h00, 0, 1, 8'h5A};
        hv[3] = '{1, 1, 9'd511, 8'hC3, 1, 0, 8'h00};
        hv[4] = '{1, 0, 9'd0,   8'h00, 1, 1, 8'h11};
        hv[5] = '{1, 0, 9'd511, 8'h00, 1, 1, 8'hC3};
        hv[6] = '{0, 1, 9'd4,   8'h77, 0, 1, 8'hC3};
        lv[0] = '{4'd0,  1,  0, 0};
        lv[1] = '{4'd1,  3,  1, 1};
        lv[2] = '{4'd2,  5,  1, 1};
        lv[3] = '{4'd8,  17, 1, 1};
        lv[4] = '{4'd9,  17, 1, 1};
        lv[5] = '{4'd15, 17, 1, 1};

        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        pass_wr = 0; pass_idx = '0; pass_key = '0; pass_mask = '0; pass_data = '0;
        num_passes = '0; start = 0;
        for (int i = 0; i < CQ; i++) begin init_mem[i] = '0; mem[i] = '0; end
        for (int i = 0; i < MP; i++) begin tbl_key[i] = '0; tbl_mask[i] = '0; tbl_data[i] = '0; end

        // Reset values
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_any", any_match, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_mode", cam_mode, 0);
        chk("rst_ap", cam_wea_ctrl_ap, 0);
        step(); step();
        rst = 1'b1;

        // Host access vectors
        init_mem[0] = 8'h11;
        load_mem();
        foreach (hv[i]) begin
            host_req = hv[i].req; host_we = hv[i].we; host_addr = hv[i].addr;
            host_wdata = hv[i].wdata;
            #1;
            chk("host_gnt", host_gnt, hv[i].exp_gnt);
            chk("host_wea", cam_wea, hv[i].req & hv[i].we);
            if (hv[i].chk_rd) chk("host_rdata", host_rdata, hv[i].exp_rd);
            if (!hv[i].req) chk("idle_key", {cam_key, cam_mask}, 0);
            step();
        end
        host_req = 0; host_we = 0;

        // Single pass
        for (int i = 0; i < CQ; i++) init_mem[i] = '0;
        init_mem[0] = 8'h0F; init_mem[7] = 8'h0F; init_mem[9] = 8'h0F;
        load_mem();
        prog(0, 8'h0F, 8'hFF, 8'hF0);
        model_run(1, eany);
        run(4'd1, 1'b0, lat, ap, bg);
        chk("p1_lat", lat, 3);
        chk("p1_any", any_match, 1);
        chk("p1_row7", mem[7], 8'hF0);
        chk("p1_mem", mem_diff(), 0);

        // Three passes, middle one matches nothing
        load_mem();
        prog(1, 8'h33, 8'hFF, 8'h77);
        prog(2, 8'h00, 8'hFF, 8'h11);
        model_run(3, eany);
        run(4'd3, 1'b0, lat, ap, bg);
        chk("p3_lat", lat, 7);
        chk("p3_any", any_match, eany);
        chk("p3_row9", mem[9], 8'hF0);
        chk("p3_row1", mem[1], 8'h11);
        chk("p3_mem", mem_diff(), 0);

        // Latency and clamping with host/pass-table traffic held during busy
        for (int i = 0; i < CQ; i++) init_mem[i] = '0;
        load_mem();
        for (int i = 0; i < MP; i++) prog(i, 8'h00, 8'h00, 8'h00);
        foreach (lv[i]) begin
            model_run(int'(lv[i].np), eany);
            run(lv[i].np, 1'b1, lat, ap, bg);
            chk("tbl_lat", lat, lv[i].exp_lat);
            chk("tbl_any", any_match, lv[i].exp_any);
            chk("tbl_ap", ap, lv[i].exp_ap);
            chk("tbl_busy_gnt", bg, 0);
            chk("tbl_mem", mem_diff(), 0);
        end
        // Pass entry 0 must still be the match-all pass
        run(4'd1, 1'b0, lat, ap, bg);
        chk("pass_wr_ignored", any_match, 1);

        // Reset during WR of pass 1 of 3
        for (int i = 0; i < CQ; i++) init_mem[i] = '0;
        init_mem[0] = 8'h0F; init_mem[7] = 8'h0F; init_mem[9] = 8'h0F;
        load_mem();
        prog(0, 8'h0F, 8'hFF, 8'hF0);
        prog(1, 8'h00, 8'hFF, 8'h22);
        prog(2, 8'hF0, 8'hFF, 8'h99);
        model_run(1, eany);
        num_passes = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("abort_in_wr", cam_mode, 1);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mode", cam_mode, 0);
        chk("abort_ap", cam_wea_ctrl_ap, 0);
        chk("abort_any", any_match, 0);
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < MP; i++) begin tbl_key[i] = '0; tbl_mask[i] = '0; tbl_data[i] = '0; end
        dn = 0;
        repeat (5) begin
            step();
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_mem", mem_diff(), 0);

        // Randomized programs against the reference model
        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < CQ; r++) init_mem[r] = WS'($urandom_range(0, 7));
            load_mem();
            for (int p = 0; p < MP; p++)
                prog(p, WS'($urandom_range(0, 7)), masks[$urandom_range(0, 5)],
                     WS'($urandom_range(0, 7)));
            np = (PW+1)'($urandom_range(0, 9));
            model_run(int'(np), eany);
            run(np, it[0], lat, ap, bg);
            chk("rnd_lat", lat, 2 * ((int'(np) > MP) ? MP : int'(np)) + 1);
            chk("rnd_any", any_match, eany);
            chk("rnd_busy_gnt", bg, 0);
            chk("rnd_mem", mem_diff(), 0);
            a = AW'($urandom_range(0, CQ - 1));
            host_req = 1'b1; host_we = 1'b0; host_addr = a;
            #1;
            chk("rnd_rdata", host_rdata, exp_mem[a]);
            step();
            host_req = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
